// File: rtl/cluster_cken_seq_pkg.sv
// Shared types and helpers for the cluster clock-enable sequencer.
package cluster_cken_seq_pkg;

   typedef enum logic [2:0] {
      RAMP_WAIT = 3'd0,
      RAMP      = 3'd1,
      RST_HOLD  = 3'd2,
      DBG_HOLD  = 3'd3,
      RUN       = 3'd4
   } seq_state_t;

   // Width of a cluster index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cluster_seq_timer.sv
// Loadable down-counter that parks at zero; zero flags the step point.
module cluster_seq_timer #(
   parameter int CNT_W = 8
) (
   input  logic             gclk,
   input  logic             arst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge gclk or posedge arst) begin
      if (arst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/cluster_cken_seq.sv
// Tile-level clock-header sequencer: staggered cken bring-up, reset/debug-init
// release, then one-at-a-time runtime gate changes and debug-init re-pulses.
module cluster_cken_seq
   import cluster_cken_seq_pkg::*;
#(
   parameter int NUM_CLUSTERS = 4,
   parameter int STAGGER      = 8,
   parameter int RST_CYCLES   = 16,
   parameter int DBG_CYCLES   = 8,
   parameter int CNT_W        = 8
) (
   input  logic                             gclk,
   input  logic                             arst,
   input  logic                             dbg_req,
   input  logic                             gate_vld,
   input  logic [idx_w(NUM_CLUSTERS)-1:0]   gate_idx,
   input  logic                             gate_en,
   output logic                             gate_rdy,
   output logic                             gate_err,
   output logic [NUM_CLUSTERS-1:0]          cluster_cken,
   output logic                             grst_l,
   output logic                             gdbginit_l,
   output logic                             seq_busy
);

   localparam int IDX_W  = idx_w(NUM_CLUSTERS);
   localparam int RIDX_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] STAG_LD = CNT_W'(STAGGER - 1);
   localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] DBG_LD  = CNT_W'(DBG_CYCLES - 1);

   seq_state_t              state, state_nxt;
   logic [RIDX_W-1:0]       ramp_idx, ramp_idx_nxt;
   logic                    dbg_pend, dbg_pend_nxt;
   logic                    cool_act, cool_act_nxt;
   logic [NUM_CLUSTERS-1:0] cken_nxt, gate_dec, ramp_dec;
   logic                    grst_nxt, gdbg_nxt, rdy_nxt, err_nxt, busy_nxt;
   logic                    tmr_load, tmr_zero, cool_load, cool_zero, hs;
   logic [CNT_W-1:0]        tmr_val;

   cluster_seq_timer #(.CNT_W(CNT_W)) u_step_tmr (
      .gclk     (gclk),
      .arst     (arst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   cluster_seq_timer #(.CNT_W(CNT_W)) u_cool_tmr (
      .gclk     (gclk),
      .arst     (arst),
      .load     (cool_load),
      .load_val (STAG_LD),
      .zero     (cool_zero)
   );

   // Out-of-range gate_idx decodes to no bit, which is what flags gate_err.
   always_comb begin
      gate_dec = '0;
      ramp_dec = '0;
      for (int unsigned i = 0; i < NUM_CLUSTERS; i++) begin
         if (gate_idx == IDX_W'(i)) gate_dec[i] = 1'b1;
         if (ramp_idx == RIDX_W'(i)) ramp_dec[i] = 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      ramp_idx_nxt = ramp_idx;
      dbg_pend_nxt = dbg_pend | dbg_req;
      cool_act_nxt = cool_act & ~cool_zero;
      cken_nxt     = cluster_cken;
      grst_nxt     = grst_l;
      gdbg_nxt     = gdbginit_l;
      err_nxt      = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      cool_load    = 1'b0;
      hs           = gate_vld & gate_rdy;

      if (hs) begin
         cken_nxt     = (cluster_cken & ~gate_dec) | (gate_dec & {NUM_CLUSTERS{gate_en}});
         err_nxt      = ~|gate_dec;
         cool_load    = 1'b1;
         cool_act_nxt = 1'b1;
      end

      case (state)
         RAMP_WAIT: begin
            cken_nxt     = cluster_cken | ramp_dec;
            ramp_idx_nxt = ramp_idx + 1'b1;
            tmr_load     = 1'b1;
            tmr_val      = STAG_LD;
            state_nxt    = RAMP;
         end
         RAMP: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if (ramp_idx == RIDX_W'(NUM_CLUSTERS)) begin
                  tmr_val   = RST_LD;
                  state_nxt = RST_HOLD;
               end else begin
                  cken_nxt     = cluster_cken | ramp_dec;
                  ramp_idx_nxt = ramp_idx + 1'b1;
                  tmr_val      = STAG_LD;
               end
            end
         end
         RST_HOLD: begin
            if (tmr_zero) begin
               grst_nxt  = 1'b1;
               tmr_load  = 1'b1;
               tmr_val   = DBG_LD;
               state_nxt = DBG_HOLD;
            end
         end
         DBG_HOLD: begin
            // A pending request chains straight into another hold so
            // gdbginit_l never blips high between them.
            if (tmr_zero) begin
               if (dbg_pend | dbg_req) begin
                  tmr_load     = 1'b1;
                  tmr_val      = DBG_LD;
                  dbg_pend_nxt = 1'b0;
               end else begin
                  gdbg_nxt  = 1'b1;
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            dbg_pend_nxt = 1'b0;
            if (dbg_req) begin
               gdbg_nxt  = 1'b0;
               tmr_load  = 1'b1;
               tmr_val   = DBG_LD;
               state_nxt = DBG_HOLD;
            end
         end
         default: state_nxt = RAMP_WAIT;
      endcase

      rdy_nxt  = (state_nxt == RUN) & ~cool_act_nxt;
      busy_nxt = (state_nxt != RUN);
   end

   always_ff @(posedge gclk or posedge arst) begin
      if (arst) begin
         state        <= RAMP_WAIT;
         ramp_idx     <= '0;
         dbg_pend     <= 1'b0;
         cool_act     <= 1'b0;
         cluster_cken <= '0;
         grst_l       <= 1'b0;
         gdbginit_l   <= 1'b0;
         gate_rdy     <= 1'b0;
         gate_err     <= 1'b0;
         seq_busy     <= 1'b1;
      end else begin
         state        <= state_nxt;
         ramp_idx     <= ramp_idx_nxt;
         dbg_pend     <= dbg_pend_nxt;
         cool_act     <= cool_act_nxt;
         cluster_cken <= cken_nxt;
         grst_l       <= grst_nxt;
         gdbginit_l   <= gdbg_nxt;
         gate_rdy     <= rdy_nxt;
         gate_err     <= err_nxt;
         seq_busy     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_cluster_cken_seq.sv
// Directed bench for cluster_cken_seq: a 4-cluster instance and a 3-cluster instance.
module tb_cluster_cken_seq;

   logic       gclk = 1'b0;
   logic       arst = 1'b1;
   logic       dbg_req = 1'b0, gate_vld = 1'b0, gate_en = 1'b0;
   logic [1:0] gate_idx = 2'd0;
   logic       gate_rdy, gate_err, grst_l, gdbginit_l, seq_busy;
   logic [3:0] cluster_cken;

   logic       dbg3 = 1'b0, vld3 = 1'b0, en3 = 1'b0;
   logic [1:0] idx3 = 2'd0;
   logic       rdy3, err3, grst3, gdbg3, busy3;
   logic [2:0] cken3;

   int checks = 0;
   int errors = 0;

   always #5 gclk = ~gclk;

   cluster_cken_seq #(
      .NUM_CLUSTERS(4), .STAGGER(8), .RST_CYCLES(16), .DBG_CYCLES(8), .CNT_W(8)
   ) dut (
      .gclk(gclk), .arst(arst), .dbg_req(dbg_req), .gate_vld(gate_vld),
      .gate_idx(gate_idx), .gate_en(gate_en), .gate_rdy(gate_rdy), .gate_err(gate_err),
      .cluster_cken(cluster_cken), .grst_l(grst_l), .gdbginit_l(gdbginit_l),
      .seq_busy(seq_busy)
   );

   cluster_cken_seq #(
      .NUM_CLUSTERS(3), .STAGGER(8), .RST_CYCLES(16), .DBG_CYCLES(8), .CNT_W(8)
   ) dut3 (
      .gclk(gclk), .arst(arst), .dbg_req(dbg3), .gate_vld(vld3),
      .gate_idx(idx3), .gate_en(en3), .gate_rdy(rdy3), .gate_err(err3),
      .cluster_cken(cken3), .grst_l(grst3), .gdbginit_l(gdbg3), .seq_busy(busy3)
   );

   wire [7:0] obs4 = {cluster_cken, grst_l, gdbginit_l, gate_rdy, seq_busy, gate_err};
   wire [7:0] obs3 = {cken3, grst3, gdbg3, rdy3, busy3, err3};

   // Expected {cken, grst_l, gdbginit_l, gate_rdy, seq_busy, gate_err} after edge Ek.
   function automatic logic [7:0] exp4(input int k, input int run_k);
      logic [3:0] c;
      for (int i = 0; i < 4; i++) c[i] = (k >= 8 * i);
      return {c, k >= 48, k >= run_k, k >= run_k, k < run_k, 1'b0};
   endfunction

   function automatic logic [7:0] exp3(input int k);
      logic [2:0] c;
      for (int i = 0; i < 3; i++) c[i] = (k >= 8 * i);
      return {c, k >= 40, k >= 48, k >= 48, k < 48, 1'b0};
   endfunction

   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   // Leaves arst low just after an edge, so the next edge is E0.
   task automatic release_rst();
      arst = 1'b1;
      tick();
      tick();
      arst = 1'b0;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      tick();
      tick();
      checks++;
      if (obs4 !== 8'b0000_0010) begin
         errors++;
         $display("FAIL reset4 got %b want %b", obs4, 8'b0000_0010);
      end
      checks++;
      if (obs3 !== 8'b000_00010) begin
         errors++;
         $display("FAIL reset3 got %b want %b", obs3, 8'b000_00010);
      end
   endtask

   task automatic test_bringup();
      release_rst();
      for (int k = 0; k < 60; k++) begin
         tick();
         checks++;
         if (obs4 !== exp4(k, 56)) begin
            errors++;
            $display("FAIL bringup4 E%0d got %b want %b", k, obs4, exp4(k, 56));
         end
         checks++;
         if (obs3 !== exp3(k)) begin
            errors++;
            $display("FAIL bringup3 E%0d got %b want %b", k, obs3, exp3(k));
         end
      end
   endtask

   task automatic test_gate();
      gate_vld = 1'b1; gate_idx = 2'd2; gate_en = 1'b0;
      tick();
      checks++;
      if ({cluster_cken, gate_rdy, gate_err} !== 6'b1011_0_0) begin
         errors++;
         $display("FAIL gate_off got %b want %b", {cluster_cken, gate_rdy, gate_err}, 6'b1011_0_0);
      end
      // Next request is held through the cooldown and must wait for gate_rdy.
      gate_en = 1'b1;
      for (int c = 1; c < 8; c++) begin
         tick();
         checks++;
         if ({cluster_cken, gate_rdy} !== 5'b1011_0) begin
            errors++;
            $display("FAIL gate_cool c%0d got %b want %b", c, {cluster_cken, gate_rdy}, 5'b1011_0);
         end
      end
      tick();
      checks++;
      if ({cluster_cken, gate_rdy} !== 5'b1011_1) begin
         errors++;
         $display("FAIL gate_rdy_back got %b want %b", {cluster_cken, gate_rdy}, 5'b1011_1);
      end
      tick();
      gate_vld = 1'b0;
      checks++;
      if ({cluster_cken, gate_rdy, gate_err} !== 6'b1111_0_0) begin
         errors++;
         $display("FAIL gate_on got %b want %b", {cluster_cken, gate_rdy, gate_err}, 6'b1111_0_0);
      end
      for (int c = 1; c < 9; c++) tick();
      checks++;
      if (gate_rdy !== 1'b1) begin
         errors++;
         $display("FAIL gate_rdy_final got %b want 1", gate_rdy);
      end
   endtask

   task automatic test_gate_err();
      vld3 = 1'b1; idx3 = 2'd3; en3 = 1'b0;
      tick();
      vld3 = 1'b0;
      checks++;
      if ({cken3, err3, rdy3} !== 5'b111_1_0) begin
         errors++;
         $display("FAIL err_pulse got %b want %b", {cken3, err3, rdy3}, 5'b111_1_0);
      end
      tick();
      checks++;
      if ({cken3, err3, rdy3} !== 5'b111_0_0) begin
         errors++;
         $display("FAIL err_clear got %b want %b", {cken3, err3, rdy3}, 5'b111_0_0);
      end
      for (int c = 2; c < 8; c++) begin
         tick();
         checks++;
         if (rdy3 !== 1'b0) begin
            errors++;
            $display("FAIL err_cool c%0d got %b want 0", c, rdy3);
         end
      end
      tick();
      checks++;
      if (rdy3 !== 1'b1) begin
         errors++;
         $display("FAIL err_rdy_back got %b want 1", rdy3);
      end
      vld3 = 1'b1; idx3 = 2'd1; en3 = 1'b0;
      tick();
      vld3 = 1'b0;
      checks++;
      if ({cken3, err3} !== 4'b101_0) begin
         errors++;
         $display("FAIL err_valid got %b want %b", {cken3, err3}, 4'b101_0);
      end
   endtask

   task automatic test_dbg_run();
      dbg_req = 1'b1;
      tick();
      dbg_req = 1'b0;
      checks++;
      if ({gdbginit_l, gate_rdy, seq_busy} !== 3'b001) begin
         errors++;
         $display("FAIL dbgrun_start got %b want 001", {gdbginit_l, gate_rdy, seq_busy});
      end
      for (int c = 1; c < 8; c++) begin
         tick();
         checks++;
         if ({gdbginit_l, gate_rdy, seq_busy} !== 3'b001) begin
            errors++;
            $display("FAIL dbgrun_hold c%0d got %b want 001", c, {gdbginit_l, gate_rdy, seq_busy});
         end
      end
      tick();
      checks++;
      if ({gdbginit_l, gate_rdy, seq_busy, cluster_cken, grst_l} !== 8'b110_1111_1) begin
         errors++;
         $display("FAIL dbgrun_end got %b want %b",
                  {gdbginit_l, gate_rdy, seq_busy, cluster_cken, grst_l}, 8'b110_1111_1);
      end
   endtask

   task automatic test_simul();
      gate_vld = 1'b1; gate_idx = 2'd1; gate_en = 1'b0; dbg_req = 1'b1;
      tick();
      gate_vld = 1'b0; dbg_req = 1'b0;
      checks++;
      if ({cluster_cken, gdbginit_l, gate_rdy} !== 6'b1101_0_0) begin
         errors++;
         $display("FAIL simul_edge got %b want %b", {cluster_cken, gdbginit_l, gate_rdy}, 6'b1101_0_0);
      end
      for (int c = 1; c < 8; c++) begin
         tick();
         checks++;
         if ({gdbginit_l, gate_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL simul_hold c%0d got %b want 00", c, {gdbginit_l, gate_rdy});
         end
      end
      tick();
      checks++;
      if ({cluster_cken, gdbginit_l, gate_rdy} !== 6'b1101_1_1) begin
         errors++;
         $display("FAIL simul_end got %b want %b", {cluster_cken, gdbginit_l, gate_rdy}, 6'b1101_1_1);
      end
   endtask

   task automatic test_mid_reset();
      release_rst();
      for (int k = 0; k <= 30; k++) tick();
      checks++;
      if (obs4 !== exp4(30, 56)) begin
         errors++;
         $display("FAIL midrst_pre got %b want %b", obs4, exp4(30, 56));
      end
      arst = 1'b1;
      #1;
      checks++;
      if (obs4 !== 8'b0000_0010) begin
         errors++;
         $display("FAIL midrst_async4 got %b want %b", obs4, 8'b0000_0010);
      end
      checks++;
      if (obs3 !== 8'b000_00010) begin
         errors++;
         $display("FAIL midrst_async3 got %b want %b", obs3, 8'b000_00010);
      end
   endtask

   // Restart timeline with a dbg_req pulse during the ramp: one extra hold.
   task automatic test_dbg_pending();
      release_rst();
      for (int k = 0; k < 66; k++) begin
         dbg_req = (k == 20);
         tick();
         dbg_req = 1'b0;
         checks++;
         if (obs4 !== exp4(k, 64)) begin
            errors++;
            $display("FAIL dbgpend4 E%0d got %b want %b", k, obs4, exp4(k, 64));
         end
         checks++;
         if (obs3 !== exp3(k)) begin
            errors++;
            $display("FAIL restart3 E%0d got %b want %b", k, obs3, exp3(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_gate();
      test_gate_err();
      test_dbg_run();
      test_simul();
      test_mid_reset();
      test_dbg_pending();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
